// File: rtl/stack_arbiter.sv
// Round-robin arbiter/sequencer sharing one push-down stack between NREQ
// requesters. One transaction in flight; outputs are registered from state.
module stack_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int PTRW      = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           op,
  input  logic [NREQ*DATAWIDTH-1:0] wdata,
  output logic [NREQ-1:0]           ack,
  output logic                      err,
  output logic [DATAWIDTH-1:0]      rdata,
  output logic                      busy,
  output logic                      stk_en,
  output logic                      stk_pushpop,
  output logic [DATAWIDTH-1:0]      stk_wdata,
  input  logic [DATAWIDTH-1:0]      stk_rdata,
  input  logic                      stk_empty,
  input  logic                      stk_full
);

  typedef enum logic [2:0] {IDLE, PUSH, POP_RD, POP_UPD, DONE} state_t;

  state_t                 state;
  logic [PTRW-1:0]        ptr;
  logic [PTRW-1:0]        gnt;
  logic                   found;
  logic [PTRW-1:0]        win;
  logic                   win_op;
  logic [DATAWIDTH-1:0]   win_data;
  logic [DATAWIDTH-1:0]   lane_wdata [NREQ];

  // Split the flat push-data bus into one word per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_wdata[i] = wdata[i*DATAWIDTH +: DATAWIDTH];
  end

  function automatic logic [NREQ-1:0] onehot(input logic [PTRW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Pointer moves just past the requester that was served.
  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] i);
    next_ptr = (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Round-robin search: first set req at or above ptr, wrapping at NREQ.
  always_comb begin
    logic [PTRW-1:0] cand;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTRW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_op   = op[win];
  assign win_data = lane_wdata[win];

  // Sequencer FSM; every output is a register updated on the state transition.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt         <= '0;
      ack         <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      stk_en      <= 1'b0;
      stk_pushpop <= 1'b0;
      stk_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt  <= win;
            busy <= 1'b1;
            // Flags are only trusted here: nothing else drives the stack.
            if (win_op ? stk_full : stk_empty) begin
              state <= DONE;
              ack   <= onehot(win);
              err   <= 1'b1;
              ptr   <= next_ptr(win);
            end else if (win_op) begin
              state       <= PUSH;
              stk_en      <= 1'b1;
              stk_pushpop <= 1'b0;
              stk_wdata   <= win_data;
            end else begin
              state       <= POP_RD;
              stk_en      <= 1'b0;
              stk_pushpop <= 1'b1;
            end
          end
        end
        PUSH: begin
          state     <= DONE;
          stk_en    <= 1'b0;
          stk_wdata <= '0;
          ack       <= onehot(gnt);
          err       <= 1'b0;
          ptr       <= next_ptr(gnt);
        end
        POP_RD: begin
          // pushpop=1 has the stack presenting top-1, i.e. the word to pop.
          rdata  <= stk_rdata;
          state  <= POP_UPD;
          stk_en <= 1'b1;
        end
        POP_UPD: begin
          state       <= DONE;
          stk_en      <= 1'b0;
          stk_pushpop <= 1'b0;
          ack         <= onehot(gnt);
          err         <= 1'b0;
          ptr         <= next_ptr(gnt);
        end
        DONE: begin
          state <= IDLE;
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          ack         <= '0;
          err         <= 1'b0;
          busy        <= 1'b0;
          stk_en      <= 1'b0;
          stk_pushpop <= 1'b0;
          stk_wdata   <= '0;
        end
      endcase
    end
  end

endmodule
